// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: received word, status flags and acknowledge.
// valid/ready: rx_valid stays high until an edge with rx_ack high and no new word arriving on that same edge.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification, LSB-first data, optional parity, stop check.
// A completed frame is presented one clk after the stop-sample tick and held until acknowledged.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clk,
    input  logic [1:0] parity_mode,
    input  logic       rx,
    uart_rx_if.master  bus,
    output logic [2:0] state_dbg
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 done_q, done_d;
    logic                 sync1_q, rx_s;
    logic                 baud_q;
    logic                 tick;

    assign tick      = baud_clk & ~baud_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b1;
            rx_s      <= 1'b1;
            baud_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rx_s      <= sync1_q;
            baud_q    <= baud_clk;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        done_d    = 1'b0;
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        // Parity selection is frozen for the whole frame here.
                        state_d   = START;
                        par_en_d  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
                        par_odd_d = (parity_mode == 2'd2);
                        perr_d    = 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        bit_d = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            bit_d   = '0;
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        perr_d  = (^shift_q) ^ rx_s ^ par_odd_q;
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Back to IDLE at mid-stop so the next start edge is not missed.
                    if (cnt_q == CNT_LAST) begin
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else if (done_q) begin
            bus.rx_data    <= shift_q;
            bus.parity_err <= perr_q;
            bus.frame_err  <= ferr_q;
            bus.rx_valid   <= 1'b1;
            // An ack landing with the new word retires the old one cleanly.
            if (bus.rx_valid)
                bus.overrun <= ~bus.rx_ack;
        end else if (bus.rx_valid && bus.rx_ack) begin
            bus.rx_valid <= 1'b0;
            bus.overrun  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are scheduled in bit periods, a frame-level model predicts
// the delivered word and flags, and a per-cycle compare checks the DUT against it.
module tb_uart_rx;
    localparam int W = 8;
    localparam logic [14:0] ALL = 15'h7fff;
    localparam logic [14:0] OUT = 15'h0fff;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       baud_clk = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] parity_mode = 2'd0;
    logic [2:0] state_dbg;
    int         ecnt = 0;
    int         tests = 0;
    int         fails = 0;

    uart_rx_if #(.DATA_BITS(W)) bus ();

    uart_rx #(.DATA_BITS(W), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .baud_clk(baud_clk), .parity_mode(parity_mode),
        .rx(rx), .bus(bus), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Baud toggles every clk, so a tick lands on every edge that leaves ecnt even.
    always @(posedge clk) begin
        ecnt     <= ecnt + 1;
        baud_clk <= ~baud_clk;
    end

    // Pending deliveries: {edge number, parity_err, frame_err, data}.
    logic [W+33:0] exp_q[$];
    int            rd_idx = 0;
    logic          exp_valid, exp_pe, exp_fe, exp_ovr;
    logic [W-1:0]  exp_data;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx    = exp_q.size();
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_pe    = 1'b0;
            exp_fe    = 1'b0;
            exp_ovr   = 1'b0;
        end else if (rd_idx < exp_q.size() && exp_q[rd_idx][W+33:W+2] == 32'(ecnt + 1)) begin
            if (exp_valid) exp_ovr = !bus.rx_ack;
            exp_valid = 1'b1;
            {exp_pe, exp_fe, exp_data} = exp_q[rd_idx][W+1:0];
            rd_idx++;
        end else if (exp_valid && bus.rx_ack) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    end

    int          lit_seq = 0;
    int          lit_done = 0;
    string       lit_name;
    logic [14:0] lit_exp, lit_mask;

    always @(negedge clk) begin : cmp
        logic [11:0] dut_v;
        logic [11:0] mdl_v;
        dut_v = {bus.rx_valid, bus.rx_data, bus.parity_err, bus.frame_err, bus.overrun};
        mdl_v = {exp_valid, exp_data, exp_pe, exp_fe, exp_ovr};
        tests++;
        if (dut_v !== mdl_v) begin
            fails++;
            $display("FAIL cycle@%0d v/d/pe/fe/ov got=%b/%h/%b/%b/%b required=%b/%h/%b/%b/%b", ecnt,
                     dut_v[11], dut_v[10:3], dut_v[2], dut_v[1], dut_v[0],
                     mdl_v[11], mdl_v[10:3], mdl_v[2], mdl_v[1], mdl_v[0]);
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            tests++;
            if (({state_dbg, dut_v} & lit_mask) !== (lit_exp & lit_mask)) begin
                fails++;
                $display("FAIL %s: got=%h required=%h mask=%h", lit_name, {state_dbg, dut_v}, lit_exp, lit_mask);
            end
            if (lit_mask[11:0] != 12'h0) begin
                tests++;
                if ((mdl_v & lit_mask[11:0]) !== (lit_exp[11:0] & lit_mask[11:0])) begin
                    fails++;
                    $display("FAIL %s_model: got=%h required=%h", lit_name, mdl_v, lit_exp[11:0]);
                end
            end
        end
    end

    function automatic logic [14:0] mk(input logic [2:0] st, input logic v, input logic [7:0] d,
                                       input logic pe, input logic fe, input logic ov);
        return {st, v, d, pe, fe, ov};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic align();
        step(1);
        if (ecnt % 2 != 0) step(1);
    endtask

    task automatic expect_lit(input string name, input logic [14:0] e, input logic [14:0] m);
        lit_name = name;
        lit_exp  = e;
        lit_mask = m;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    task automatic ack();
        bus.rx_ack = 1'b1;
        step(1);
        bus.rx_ack = 1'b0;
    endtask

    // Stop sample falls 20 edges into the stop bit; a low stop is released just before the next tick sees it.
    task automatic send_frame(input logic [W-1:0] d, input logic [1:0] pm, input logic pb,
                              input logic stop_v, input logic ack_done);
        int   e0, nb, dedge;
        logic par_on, pe;
        align();
        par_on = (pm == 2'd1) || (pm == 2'd2);
        nb     = W + (par_on ? 1 : 0);
        e0     = ecnt;
        dedge  = e0 + 21 + 32 * (nb + 1);
        pe     = par_on && (((^d) ^ pb) != (pm == 2'd2));
        exp_q.push_back({32'(dedge), pe, ~stop_v, d});
        parity_mode = pm;
        rx = 1'b0;
        step(32);
        for (int i = 0; i < W; i++) begin
            rx = d[i];
            step(32);
        end
        if (par_on) begin
            rx = pb;
            step(32);
        end
        for (int i = 0; i < 32; i++) begin
            rx = (i < 19) ? stop_v : 1'b1;
            bus.rx_ack = ack_done && (ecnt == dedge - 1);
            step(1);
        end
        bus.rx_ack = 1'b0;
        rx = 1'b1;
    endtask

    task automatic send_abort(input logic [W-1:0] d);
        align();
        parity_mode = 2'd0;
        rx = 1'b0;
        step(32);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            step(32);
        end
        rx = d[4];
        step(10);
        #1 reset = 1'b0;
        rx = 1'b1;
        step(1);
        expect_lit("reset_mid_frame", mk(3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), ALL);
        step(2);
        #1 reset = 1'b1;
        step(40);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_ack = 1'b0;
        step(3);
        expect_lit("reset_state", mk(3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), ALL);
        #1 reset = 1'b1;
        step(4);
        expect_lit("post_reset_idle", mk(3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), ALL);

        send_frame(8'h55, 2'd0, 1'b0, 1'b1, 1'b0);
        expect_lit("frame_55", mk(3'd0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0), ALL);
        ack();

        send_frame(8'hA3, 2'd1, 1'b1, 1'b1, 1'b0);
        expect_lit("even_pb1", mk(3'd0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0), OUT);
        ack();
        send_frame(8'hA3, 2'd1, 1'b0, 1'b1, 1'b0);
        expect_lit("even_pb0", mk(3'd0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0), OUT);
        ack();
        send_frame(8'hA3, 2'd2, 1'b1, 1'b1, 1'b0);
        expect_lit("odd_pb1", mk(3'd0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0), OUT);
        ack();
        send_frame(8'hA3, 2'd2, 1'b0, 1'b1, 1'b0);
        expect_lit("odd_pb0", mk(3'd0, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b0), OUT);
        ack();
        expect_lit("ack_clears", mk(3'd0, 1'b0, 8'hA3, 1'b1, 1'b0, 1'b0), OUT);
        ack();

        align();
        rx = 1'b0;
        step(8);
        rx = 1'b1;
        step(40);
        expect_lit("glitch_rejected", mk(3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 15'h7800);
        send_frame(8'h0F, 2'd0, 1'b0, 1'b1, 1'b0);
        expect_lit("frame_0f", mk(3'd0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0), OUT);
        ack();

        send_frame(8'h12, 2'd0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, 2'd0, 1'b0, 1'b1, 1'b0);
        expect_lit("overrun_set", mk(3'd0, 1'b1, 8'h34, 1'b0, 1'b0, 1'b1), OUT);
        ack();
        expect_lit("overrun_cleared", mk(3'd0, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0), OUT);

        send_frame(8'hFF, 2'd0, 1'b0, 1'b0, 1'b0);
        expect_lit("frame_err", mk(3'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0), OUT);
        ack();

        send_frame(8'h21, 2'd0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 2'd0, 1'b0, 1'b1, 1'b1);
        expect_lit("ack_with_completion", mk(3'd0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0), OUT);
        send_frame(8'h3C, 2'd3, 1'b1, 1'b1, 1'b0);
        expect_lit("mode3_overrun", mk(3'd0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1), OUT);

        send_abort(8'hC6);
        expect_lit("after_abort", mk(3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), ALL);
        send_frame(8'hC6, 2'd0, 1'b0, 1'b1, 1'b0);
        expect_lit("frame_c6", mk(3'd0, 1'b1, 8'hC6, 1'b0, 1'b0, 1'b0), ALL);
        ack();
        step(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
